// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and alignment helpers for dmem_lsu
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_ADDR,
        ST_LD_DATA,
        ST_RMW_ADDR,
        ST_RMW_MERGE,
        ST_WR,
        ST_ERR
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            SZ_WORD: is_misaligned = |offset;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    // Direct stores copy the datum to every lane so IO sinks reading the low half see it.
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: replicate = {4{data[7:0]}};
            SZ_HALF: replicate = {2{data[15:0]}};
            default: replicate = data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - CPU request/response and DMEM word-bus signals of the load/store unit
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_ask_addr;
    logic [31:0] mem_fetch_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_ask_addr, mem_fetch_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_ask_addr, mem_fetch_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - combinational byte/half lane extract+extend and read-modify-write merge
module lsu_lane
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] merged_o
);

    logic [1:0]  lane;
    logic        half_hi;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        lane    = BIG_ENDIAN ? ~offset_i : offset_i;
        half_hi = BIG_ENDIAN ? ~offset_i[1] : offset_i[1];
        byte_v  = rd_word_i[{lane, 3'b000} +: 8];
        half_v  = rd_word_i[{half_hi, 4'b0000} +: 16];

        ld_data_o = rd_word_i;
        merged_o  = rd_word_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                merged_o[{lane, 3'b000} +: 8] = st_data_i[7:0];
            end
            SZ_HALF: begin
                ld_data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
                merged_o[{half_hi, 4'b0000} +: 16] = st_data_i[15:0];
            end
            default: merged_o = st_data_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit turning sub-word CPU accesses into word-only DMEM cycles
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int IO_SEL_BIT = 31,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_lsu_if.slave  bus
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] ld_data;
    logic [31:0] merged;
    logic [31:0] word_addr;

    lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .rd_word_i  (bus.mem_rdata),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .st_data_i  (wdata_q),
        .ld_data_o  (ld_data),
        .merged_o   (merged)
    );

    assign word_addr = {bus.req_addr[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    off_d   = bus.req_addr[1:0];
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    // Errors never touch the address bus, so mem_addr only moves on good requests.
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (!bus.req_we) begin
                        state_d    = ST_LD_ADDR;
                        mem_addr_d = word_addr;
                    end else if (bus.req_size == SZ_WORD || bus.req_addr[IO_SEL_BIT]) begin
                        state_d     = ST_WR;
                        mem_addr_d  = word_addr;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = replicate(bus.req_size, bus.req_wdata);
                    end else begin
                        state_d    = ST_RMW_ADDR;
                        mem_addr_d = word_addr;
                    end
                end
            end
            ST_LD_ADDR:  state_d = ST_LD_DATA;
            ST_LD_DATA: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_data;
                state_d      = ST_IDLE;
            end
            ST_RMW_ADDR: state_d = ST_RMW_MERGE;
            ST_RMW_MERGE: begin
                mem_wdata_d = merged;
                mem_we_d    = 1'b1;
                state_d     = ST_WR;
            end
            ST_WR: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready      = (state_q == ST_IDLE);
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_ask_addr   = mem_addr_q;
    assign bus.mem_fetch_addr = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu against a transaction-level model
module tb_dmem_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if ifc ();

    dmem_lsu #(.IO_SEL_BIT(31), .BIG_ENDIAN(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] dmem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dmem_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        logic [31:0] rd;
        cyc++;
        rd = dmem_rd(ifc.mem_ask_addr);
        if (ifc.mem_we) dmem[ifc.mem_ask_addr] = ifc.mem_wdata;
        ifc.mem_rdata <= rd;
    end

    // Transaction-level model: one outstanding op with a due cycle for its response.
    bit          have_op = 1'b0;
    int          op_due, op_acc;
    bit          op_store, op_err;
    logic [31:0] op_rdata, op_wa, op_new;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] last_rdata, last_wdata;
    logic        last_err;
    int          last_lat, prev_acc, last_acc;
    int          we_pulses = 0;

    always @(negedge rst_n) begin
        have_op  = 1'b0;
        exp_addr = 32'h0;
    end

    always @(negedge clk) begin
        bit          exp_resp, exp_idle, exp_we;
        logic [31:0] a, w, v;
        logic [1:0]  sz;
        int          lat;
        if (rst_n) begin
            exp_resp = have_op && (cyc == op_due);
            exp_idle = !have_op || (cyc >= op_due);
            exp_we   = have_op && op_store && !op_err && (cyc == op_due - 1);
            chk("resp_valid", 32'(ifc.resp_valid), 32'(exp_resp));
            if (ifc.resp_valid) begin
                last_rdata = ifc.resp_rdata;
                last_err   = ifc.resp_err;
                last_lat   = cyc - last_acc;
            end
            if (exp_resp) begin
                chk("resp_rdata", ifc.resp_rdata, op_rdata);
                chk("resp_err", 32'(ifc.resp_err), 32'(op_err));
                if (op_store && !op_err) ref_mem[op_wa] = op_new;
            end
            chk("req_ready", 32'(ifc.req_ready), 32'(exp_idle));
            chk("mem_we", 32'(ifc.mem_we), 32'(exp_we));
            chk("mem_ask_addr", ifc.mem_ask_addr, exp_addr);
            chk("mem_fetch_addr", ifc.mem_fetch_addr, exp_addr);
            if (ifc.mem_we) begin
                we_pulses++;
                last_wdata = ifc.mem_wdata;
            end
            if (exp_we) chk("mem_wdata", ifc.mem_wdata, op_new);

            if (exp_idle && ifc.req_valid) begin
                a  = ifc.req_addr;
                sz = ifc.req_size;
                op_wa    = {a[31:2], 2'b00};
                op_store = ifc.req_we;
                op_err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
                op_rdata = 32'h0;
                op_new   = 32'h0;
                w = ref_rd(op_wa);
                v = ifc.req_wdata;
                if (op_err) begin
                    lat = 2;
                end else if (!op_store) begin
                    lat = 3;
                    if (sz == 2'd0) begin
                        op_rdata = (w >> (8 * a[1:0])) & 32'hFF;
                        if (!ifc.req_unsigned && op_rdata[7]) op_rdata = op_rdata | 32'hFFFF_FF00;
                    end else if (sz == 2'd1) begin
                        op_rdata = (w >> (16 * a[1])) & 32'hFFFF;
                        if (!ifc.req_unsigned && op_rdata[15]) op_rdata = op_rdata | 32'hFFFF_0000;
                    end else begin
                        op_rdata = w;
                    end
                end else if (sz == 2'd2 || a[31]) begin
                    lat = 2;
                    op_new = (sz == 2'd0) ? (v & 32'hFF) * 32'h0101_0101 :
                             (sz == 2'd1) ? (v & 32'hFFFF) * 32'h0001_0001 : v;
                end else begin
                    lat = 4;
                    if (sz == 2'd0)
                        op_new = (w & ~(32'hFF << (8 * a[1:0]))) | ((v & 32'hFF) << (8 * a[1:0]));
                    else
                        op_new = (w & ~(32'hFFFF << (16 * a[1]))) | ((v & 32'hFFFF) << (16 * a[1]));
                end
                have_op  = 1'b1;
                op_acc   = cyc;
                op_due   = cyc + lat;
                prev_acc = last_acc;
                last_acc = cyc;
                if (!op_err) exp_addr = op_wa;
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit ok;
        ifc.req_valid    = 1'b1;
        ifc.req_we       = we;
        ifc.req_size     = size;
        ifc.req_unsigned = uns;
        ifc.req_addr     = addr;
        ifc.req_wdata    = wdata;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = ifc.req_ready;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                            input logic [31:0] exp, input int exp_lat, input string name);
        do_req(1'b0, size, uns, addr, 32'h0);
        settle();
        chk({name, "_data"}, last_rdata, exp);
        chk({name, "_lat"}, 32'(last_lat), 32'(exp_lat));
    endtask

    initial begin
        int pulses0;
        ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_size = 2'd0;
        ifc.req_unsigned = 1'b0; ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;
        dmem[32'h10]    = 32'h8180_7F01; ref_mem[32'h10] = 32'h8180_7F01;
        dmem[32'h24]    = 32'hA5A5_A5A5; ref_mem[32'h24] = 32'hA5A5_A5A5;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
        chk("rst_mem_wdata", ifc.mem_wdata, 32'd0);
        chk("rst_resp_rdata", ifc.resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(ifc.req_ready), 32'd1);

        run_load(2'd0, 1'b0, 32'h11, 32'h0000_007F, 3, "lb_11");
        run_load(2'd0, 1'b0, 32'h13, 32'hFFFF_FF81, 3, "lb_13");
        run_load(2'd0, 1'b1, 32'h13, 32'h0000_0081, 3, "lbu_13");
        run_load(2'd1, 1'b0, 32'h12, 32'hFFFF_8180, 3, "lh_12");

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        settle();
        chk("sw_lat", 32'(last_lat), 32'd2);
        pulses0 = we_pulses;
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
        settle();
        chk("sh_rmw_lat", 32'(last_lat), 32'd4);
        chk("sh_rmw_wdata", last_wdata, 32'hBEEF_3344);
        chk("sh_rmw_pulses", 32'(we_pulses - pulses0), 32'd1);
        run_load(2'd2, 1'b0, 32'h10, 32'hBEEF_3344, 3, "lw_after_sh");

        do_req(1'b1, 2'd1, 1'b0, 32'h8000_0008, 32'h0000_1234);
        settle();
        chk("sh_io_lat", 32'(last_lat), 32'd2);
        chk("sh_io_wdata", last_wdata, 32'h1234_1234);
        chk("sh_io_dmem", dmem_rd(32'h8000_0008), 32'h1234_1234);

        do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
        settle();
        chk("lw_mis_err", 32'(last_err), 32'd1);
        chk("lw_mis_rdata", last_rdata, 32'd0);
        chk("lw_mis_lat", 32'(last_lat), 32'd2);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        settle();
        chk("sz3_err", 32'(last_err), 32'd1);

        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        settle();
        chk("b2b_data", last_rdata, 32'hDEAD_BEEF);
        chk("b2b_gap", 32'(last_acc - prev_acc), 32'd2);

        pulses0 = we_pulses;
        do_req(1'b1, 2'd0, 1'b0, 32'h25, 32'h0000_0011);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", 32'(ifc.mem_we), 32'd0);
        chk("mid_rst_addr", ifc.mem_ask_addr, 32'd0);
        chk("mid_rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(ifc.req_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        settle();
        chk("mid_rst_no_write", 32'(we_pulses - pulses0), 32'd0);
        run_load(2'd2, 1'b0, 32'h24, 32'hA5A5_A5A5, 3, "lw_after_rst");

        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0077);
        settle();
        chk("sb_rmw_lat", 32'(last_lat), 32'd4);
        run_load(2'd2, 1'b0, 32'h20, 32'hDEAD_77EF, 3, "lw_after_sb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit on the CPU side of the data memory. It is the initiator for DMEM's `ask_addr`/`fetch_addr`/`we`/`wdata`/`rdata` interface.
- Turns byte, halfword and word loads and stores from the MEM stage into word-only DMEM accesses. DMEM has a synchronous BRAM read and a registered IO read.
- Sub-word stores to BRAM use read-modify-write. Loads are sign- or zero-extended.
- Holds the pipeline off with a valid/ready handshake.

Parameters:
- IO_SEL_BIT, 31: address bit selecting the memory-mapped IO region (1 = IO, 0 = BRAM).
- BIG_ENDIAN, 0: 0 = byte offset 0 maps to data[7:0]; 1 = byte offset 0 maps to data[31:24].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: load data or store acknowledge.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  set with resp_valid on a misaligned access or size 3.
- mem_we  out  1  to DMEM `we`.
- mem_ask_addr  out  32  to DMEM `ask_addr`.
- mem_fetch_addr  out  32  to DMEM `fetch_addr`; always equal to mem_ask_addr.
- mem_wdata  out  32  to DMEM `wdata`.
- mem_rdata  in  32  from DMEM `rdata`; valid the cycle after the address is driven.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low; `rst_n` low immediately forces the reset state.
  - State = IDLE.
  - mem_we = 0; mem addresses and mem_wdata = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - req_ready = 1 once out of reset.
  - Reset mid-operation abandons the access. No write is issued after reset asserts.
- Request acceptance:
  - `req_ready` = 1 only in IDLE.
  - A request is accepted on `req_valid & req_ready`. addr, size, we, unsigned and wdata are latched into registers.
  - All mem_* outputs are driven only from registered state.
- States:
  - IDLE: accept. Then:
    - misaligned → ERR;
    - load → LD_ADDR;
    - word store, or any store to the IO region → ST_WR;
    - sub-word store to BRAM → RMW_ADDR.
  - LD_ADDR: drive the word address (addr[1:0] forced to 0), mem_we = 0. → LD_DATA.
  - LD_DATA: sample mem_rdata; select the byte or half by the latched offset and endianness; extend per req_unsigned; load resp_rdata. → IDLE with resp_valid = 1 for one cycle.
  - RMW_ADDR: drive the word address, mem_we = 0. → RMW_MERGE.
  - RMW_MERGE: merge the latched data into mem_rdata at the offset lane, into a merge register. → ST_WR.
  - ST_WR: mem_we = 1, mem_wdata = merged word (RMW path) or lane-replicated data (direct path). → IDLE with resp_valid = 1 (store ack).
  - ERR: no memory access. → IDLE with resp_valid = 1, resp_err = 1.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 3 cycles;
  - direct store: 2 cycles;
  - RMW store: 4 cycles;
  - error: 2 cycles.
- A new request may be accepted in the same cycle resp_valid is high, since the state is then IDLE.
- Alignment rules:
  - half requires addr[0] = 0;
  - word requires addr[1:0] = 0;
  - size 3 is always an error.
- Lane replication on direct stores: a byte is copied to all 4 lanes, a half to both halves. This makes IO writes (DMEM `display_result` takes wdata[15:0]) correct for sh and sb.
- mem_we is high for exactly one cycle per store and never high for a load.

Decomposition:
- Shared package `lsu_pkg`:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum;
  - a function for the misalign check.
- One natural sub-module, `lsu_lane`, which is combinational and holds:
  - extract + extend (offset, size, unsigned, endian → 32-bit);
  - merge (old word, data, offset, size → new word).
- It is instantiated once. The FSM and registers stay in `dmem_lsu`.

Test Plan:
- BRAM word at 0x10 holds 0x8180_7F01. lb 0x11 → resp_rdata 0x0000_007F. lb 0x13 → 0xFFFF_FF81. lbu 0x13 → 0x0000_0081. Each arrives 3 cycles after accept; mem_we stays 0 throughout.
- sh 0x12 with wdata 0x0000_BEEF over 0x1122_3344 → exactly one read then one write cycle; mem_wdata = 0xBEEF_3344; ack 4 cycles after accept.
- IO store sh 0x8000_0008 with wdata 0x0000_1234 → no read cycle; mem_wdata = 0x1234_1234 with mem_we for 1 cycle; ack after 2 cycles.
- lw 0x0000_0006 → resp_err = 1, resp_rdata = 0, no mem_we, no address change. Size 3 gives the same result.
- Back-to-back: sw 0x20 = 0xDEAD_BEEF, then lw 0x20 accepted in the ack cycle → returns 0xDEAD_BEEF. req_ready is low in every non-IDLE cycle.
- rst_n pulsed low during RMW_MERGE → mem_we never asserts, outputs go to reset values immediately, and the next request completes normally.
